key_tx_seq: RTL

KEY_TX_SEQ -- requirements
Module: key_tx_seq

---
 rtl/key_tx_seq.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/key_tx_seq.sv
// Key byte sequencer: captures a 256-bit key on start and streams NUM_BYTES of it
// through a shared uart_tx, with inter-byte gaps, per-byte timeout and abort.
`timescale 1ns / 1ps

module key_tx_seq #(
  parameter int unsigned NUM_BYTES    = 32,
  parameter int unsigned GAP_CLKS     = 16,
  parameter int unsigned TIMEOUT_CLKS = 100000
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         start_i,
  input  logic         abort_i,
  input  logic [255:0] key_i,
  input  logic         tx_active_i,
  input  logic         tx_done_i,
  output logic         tx_dv_o,
  output logic [7:0]   tx_byte_o,
  output logic         busy_o,
  output logic         done_o,
  output logic         err_o,
  output logic [5:0]   sent_cnt_o
);

  localparam int unsigned TimerW = (TIMEOUT_CLKS > 0) ? $clog2(TIMEOUT_CLKS + 1) : 1;
  localparam int unsigned GapW   = (GAP_CLKS > 1) ? $clog2(GAP_CLKS + 1) : 1;

  localparam logic [TimerW-1:0] TimeoutVal = TimerW'(TIMEOUT_CLKS);
  localparam logic [GapW-1:0]   GapLast    = GapW'(GAP_CLKS - 1);
  localparam logic [4:0]        LastIdx    = 5'(NUM_BYTES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StSend,
    StWait,
    StGap,
    StDone
  } state_e;

  state_e              state_q, state_d;
  logic [255:0]        shadow_q, shadow_d;
  logic [4:0]          idx_q, idx_d;
  logic [5:0]          sent_q, sent_d;
  logic [TimerW-1:0]   timer_q, timer_d;
  logic [GapW-1:0]     gap_q, gap_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      shadow_q <= '0;
      idx_q    <= '0;
      sent_q   <= '0;
      timer_q  <= '0;
      gap_q    <= '0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      idx_q    <= idx_d;
      sent_q   <= sent_d;
      timer_q  <= timer_d;
      gap_q    <= gap_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    idx_d    = idx_q;
    sent_d   = sent_q;
    timer_d  = timer_q;
    gap_d    = gap_q;
    tx_dv_o  = 1'b0;
    done_o   = 1'b0;
    err_o    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          shadow_d = key_i;
          idx_d    = '0;
          sent_d   = '0;
          state_d  = StSend;
        end
      end
      StSend: begin
        if (!tx_active_i) begin
          tx_dv_o = 1'b1;
          timer_d = '0;
          state_d = StWait;
        end
      end
      StWait: begin
        // A completion arriving on the timeout cycle still counts as delivered.
        if (tx_done_i) begin
          sent_d = sent_q + 6'd1;
          if (idx_q == LastIdx) begin
            state_d = StDone;
          end else begin
            idx_d   = idx_q + 5'd1;
            gap_d   = '0;
            state_d = (GAP_CLKS == 0) ? StSend : StGap;
          end
        end else if (timer_q == TimeoutVal) begin
          err_o    = 1'b1;
          shadow_d = '0;
          state_d  = StIdle;
        end else begin
          timer_d = timer_q + TimerW'(1);
        end
      end
      StGap: begin
        if (gap_q == GapLast) begin
          state_d = StSend;
        end else begin
          gap_d = gap_q + GapW'(1);
        end
      end
      StDone: begin
        done_o   = 1'b1;
        shadow_d = '0;
        state_d  = StIdle;
      end
      default: begin
        shadow_d = '0;
        state_d  = StIdle;
      end
    endcase

    // Abort overrides everything decided above, including a same-cycle completion.
    if (abort_i && (state_q != StIdle)) begin
      state_d  = StIdle;
      shadow_d = '0;
      idx_d    = idx_q;
      sent_d   = sent_q;
      tx_dv_o  = 1'b0;
      done_o   = 1'b0;
      err_o    = 1'b0;
    end
  end

  assign busy_o     = (state_q != StIdle);
  assign tx_byte_o  = (state_q == StIdle) ? 8'h00 : shadow_q[{idx_q, 3'b000} +: 8];
  assign sent_cnt_o = sent_q;

endmodule
